// File: rtl/ms_path_replay.sv
// Captures a solver path burst (exit first) in a LIFO, checks it, and replays it start-to-exit.
// Optional macro MS_PATH_CHECK_EN enables the step/endpoint checks (done_err[2:1]).
module ms_path_replay #(
    parameter int MAX_LEN = 169,
    parameter int LEN_W   = 8      // 2**LEN_W must exceed MAX_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_not_valid,
    input  logic [3:0]       in_x,
    input  logic [3:0]       in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_x,
    output logic [3:0]       out_y,
    output logic             out_last,
    output logic             done_valid,
    output logic [LEN_W-1:0] done_len,
    output logic [3:0]       done_err,
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPLAY, S_REPORT} state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_ptr;
    logic [LEN_W-1:0] r_len;
    logic [3:0]       r_err;
    logic             r_out_valid;
    logic             r_done_valid;
    logic [LEN_W-1:0] r_done_len;
    logic [3:0]       r_done_err;
    logic             r_busy;
    logic [7:0]       r_mem [MAX_LEN];

    logic             w_beat;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [LEN_W-1:0] w_rd_idx;
    logic [7:0]       w_top;
    logic             w_step_err;
    logic             w_first_err;
    logic             w_last_err;

    assign w_beat   = in_valid & ~in_not_valid;
    assign w_full   = (r_ptr == LEN_W'(MAX_LEN));
    assign w_push   = w_beat & ((r_state == S_IDLE) | ((r_state == S_COLLECT) & ~w_full));
    assign w_pop    = (r_state == S_REPLAY) & r_out_valid & out_ready;
    assign w_rd_idx = (r_ptr == '0) ? '0 : r_ptr - 1'b1;
    assign w_top    = r_mem[w_rd_idx];

`ifdef MS_PATH_CHECK_EN
    logic [3:0] r_prev_x;
    logic [3:0] r_prev_y;
    logic [3:0] w_dx;
    logic [3:0] w_dy;
    logic [4:0] w_dist;

    assign w_dx        = (in_x >= r_prev_x) ? in_x - r_prev_x : r_prev_x - in_x;
    assign w_dy        = (in_y >= r_prev_y) ? in_y - r_prev_y : r_prev_y - in_y;
    assign w_dist      = {1'b0, w_dx} + {1'b0, w_dy};
    assign w_step_err  = (w_dist != 5'd1);
    assign w_first_err = (in_x != 4'd13) | (in_y != 4'd13);
    assign w_last_err  = (r_prev_x != 4'd1) | (r_prev_y != 4'd1);

    // Tracks the last beat seen, including dropped overflow beats, so the exit check sees the true tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_x <= '0;
            r_prev_y <= '0;
        end else if (w_beat & ((r_state == S_IDLE) | (r_state == S_COLLECT))) begin
            r_prev_x <= in_x;
            r_prev_y <= in_y;
        end
    end
`else
    assign w_step_err  = 1'b0;
    assign w_first_err = 1'b0;
    assign w_last_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_ptr] <= {in_x, in_y};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_len        <= '0;
            r_err        <= '0;
            r_out_valid  <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_len   <= '0;
            r_done_err   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_done_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_busy <= 1'b1;
                        if (in_not_valid) begin
                            r_len   <= '0;
                            r_err   <= 4'b0001;
                            r_state <= S_REPORT;
                        end else begin
                            r_ptr   <= LEN_W'(1);
                            r_err   <= {1'b0, w_first_err, 2'b00};
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (in_valid) begin
                        if (in_not_valid) begin
                            r_err[0] <= 1'b1;
                            r_len    <= r_ptr;
                            r_state  <= S_REPORT;
                        end else begin
                            if (w_step_err)
                                r_err[1] <= 1'b1;
                            if (w_full)
                                r_err[3] <= 1'b1;
                            else
                                r_ptr <= r_ptr + 1'b1;
                        end
                    end else begin
                        // Burst ended: the tail check must feed this cycle's replay/report decision.
                        r_len <= r_ptr;
                        if (w_last_err)
                            r_err[2] <= 1'b1;
                        if ((r_err | {1'b0, w_last_err, 2'b00}) != 4'b0000) begin
                            r_state <= S_REPORT;
                        end else begin
                            r_state     <= S_REPLAY;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_REPLAY: begin
                    if (w_pop) begin
                        r_ptr <= r_ptr - 1'b1;
                        if (r_ptr == LEN_W'(1)) begin
                            r_out_valid <= 1'b0;
                            r_state     <= S_REPORT;
                        end
                    end
                end
                S_REPORT: begin
                    r_done_valid <= 1'b1;
                    r_done_len   <= r_len;
                    r_done_err   <= r_err;
                    r_ptr        <= '0;
                    r_err        <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_x      = r_out_valid ? w_top[7:4] : 4'd0;
    assign out_y      = r_out_valid ? w_top[3:0] : 4'd0;
    assign out_last   = r_out_valid & (r_ptr == LEN_W'(1));
    assign done_valid = r_done_valid;
    assign done_len   = r_done_len;
    assign done_err   = r_done_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_ms_path_replay.sv
// Scoreboard bench for ms_path_replay: stimulus pushes expected replay beats and summaries,
// a negedge monitor pops and compares whenever the DUT presents a beat or a summary.
module tb_ms_path_replay;
    localparam int MAX_LEN = 169;
    localparam int LEN_W   = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_not_valid = 1'b0;
    logic [3:0]       in_x = '0;
    logic [3:0]       in_y = '0;
    logic             out_ready = 1'b1;
    logic             out_valid;
    logic [3:0]       out_x;
    logic [3:0]       out_y;
    logic             out_last;
    logic             done_valid;
    logic [LEN_W-1:0] done_len;
    logic [3:0]       done_err;
    logic             busy;

    ms_path_replay #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_not_valid(in_not_valid),
        .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_last(out_last), .done_valid(done_valid),
        .done_len(done_len), .done_err(done_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errs   = 0;
    int         hs_cnt   = 0;
    logic       ready_toggle = 1'b0;
    logic [8:0] exp_beat[$];
    logic [11:0] exp_done[$];
    logic [7:0] path[$];
    logic [8:0] m_e9;
    logic [11:0] m_e12;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: decoupled from stimulus, compares against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_beat.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_beat: got x=%0d y=%0d last=%0b, expected no beat", out_x, out_y, out_last);
            end else if (out_ready) begin
                m_e9 = exp_beat.pop_front();
                chk("beat", 32'({out_last, out_x, out_y}), 32'(m_e9));
                hs_cnt++;
            end else begin
                chk("stall_hold", 32'({out_last, out_x, out_y}), 32'(exp_beat[0]));
            end
        end
        if (!rst && done_valid) begin
            if (exp_done.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_done: got len=%0d err=%b, expected no summary", done_len, done_err);
            end else begin
                m_e12 = exp_done.pop_front();
                chk("done_len_err", 32'({done_len, done_err}), 32'(m_e12));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_toggle ? ~out_ready : 1'b1;
        end
    end

    task automatic build_l;
        path.delete();
        for (int y = 13; y >= 1; y--) path.push_back({4'd13, 4'(y)});
        for (int x = 12; x >= 1; x--) path.push_back({4'(x), 4'd1});
    endtask

    // (13,13)..(13,7)..(5,7) then jump to (5,9), ..(1,9)..(1,1): 28 beats, one step error.
    task automatic build_jump;
        path.delete();
        for (int y = 13; y >= 7; y--) path.push_back({4'd13, 4'(y)});
        for (int x = 12; x >= 5; x--) path.push_back({4'(x), 4'd7});
        path.push_back({4'd5, 4'd9});
        for (int x = 4; x >= 1; x--) path.push_back({4'(x), 4'd9});
        for (int y = 8; y >= 1; y--) path.push_back({4'd1, 4'(y)});
    endtask

    // 170 beats: the L path then a (2,1)/(1,1) bounce; the 170th beat is (2,1) and is dropped.
    task automatic build_ovf;
        build_l();
        for (int i = 25; i < 170; i++) path.push_back((i % 2 == 1) ? {4'd2, 4'd1} : {4'd1, 4'd1});
    endtask

    task automatic expect_replay;
        for (int i = path.size() - 1; i >= 0; i--) exp_beat.push_back({(i == 0), path[i]});
        exp_done.push_back({8'(path.size()), 4'b0000});
    endtask

    // Sends the burst; checks out_valid one cycle after in_valid falls.
    task automatic send_path(input logic exp_ov, input string name);
        foreach (path[i]) begin
            in_valid = 1'b1;
            {in_x, in_y} = path[i];
            tick();
        end
        in_valid = 1'b0;
        {in_x, in_y} = 8'h00;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_latency_out_valid"}, 32'(out_valid), 32'(exp_ov));
        chk({name, "_busy"}, 32'(busy), 32'd1);
        tick();
    endtask

    task automatic wait_drain(input int bound, input string name);
        int k;
        k = 0;
        while ((exp_beat.size() != 0 || exp_done.size() != 0) && k < bound) begin
            tick();
            k++;
        end
        if (exp_beat.size() != 0 || exp_done.size() != 0) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s_timeout: got %0d beats and %0d summaries pending, expected 0", name, exp_beat.size(), exp_done.size());
            exp_beat.delete();
            exp_done.delete();
        end
        tick();
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        int k;
        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_xy", 32'({out_x, out_y}), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_done_len", 32'(done_len), 32'd0);
        chk("rst_done_err", 32'(done_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // L path, out_ready held high
        build_l();
        chk("l_path_len", 32'(path.size()), 32'd25);
        expect_replay();
        chk("l_first_replay", 32'(exp_beat[0]), 32'h011);
        chk("l_last_replay", 32'(exp_beat[24]), 32'h1DD);
        send_path(1'b1, "l_ready");
        wait_drain(200, "l_ready");

        // Same path with out_ready toggling
        ready_toggle = 1'b1;
        expect_replay();
        send_path(1'b1, "l_toggle");
        wait_drain(300, "l_toggle");
        ready_toggle = 1'b0;
        tick();

        // Maze-not-valid pulse in IDLE
        exp_done.push_back({8'd0, 4'b0001});
        in_valid = 1'b1;
        in_not_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_not_valid = 1'b0;
        @(negedge clk);
        chk("nv_done_1cyc", 32'(done_valid), 32'd0);
        @(negedge clk);
        chk("nv_done_2cyc", 32'(done_valid), 32'd1);
        tick();
        wait_drain(20, "nv");

        // Path with a (5,7)->(5,9) jump
        build_jump();
`ifdef MS_PATH_CHECK_EN
        exp_done.push_back({8'd28, 4'b0010});
        send_path(1'b0, "jump");
`else
        expect_replay();
        send_path(1'b1, "jump");
`endif
        wait_drain(200, "jump");

        // Overflow: 170 beats, 169 kept, replay skipped
        build_ovf();
`ifdef MS_PATH_CHECK_EN
        exp_done.push_back({8'd169, 4'b1100});
`else
        exp_done.push_back({8'd169, 4'b1000});
`endif
        send_path(1'b0, "ovf");
        wait_drain(100, "ovf");

        // Reset after 10 replay beats, with out_ready high at the reset edge
        build_l();
        base = hs_cnt;
        expect_replay();
        send_path(1'b1, "rst_mid");
        k = 0;
        while (hs_cnt != base + 10 && k < 100) begin
            tick();
            k++;
        end
        chk("rst_mid_10_beats", 32'(hs_cnt - base), 32'd10);
        rst = 1'b1;
        exp_beat.delete();
        exp_done.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done_valid", 32'(done_valid), 32'd0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        expect_replay();
        send_path(1'b1, "post_rst");
        wait_drain(200, "post_rst");

        chk("final_beats_pending", 32'(exp_beat.size()), 32'd0);
        chk("final_done_pending", 32'(exp_done.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
